db_top_info_ctrl: RTL and testbench

Sequencer on the deblocking filter's port-A side of the 20x128 top-neighbour info RAM. At each LCU start it fetches the 16 stored top-neighbour words for that LCU column and streams them to the filter. It then collects the 16 bottom-row words the filter produces and writes them back to the same addresses for the next LCU row.

---
 rtl/db_defines.sv | 18 +
 rtl/db_top_info_ctrl.sv | 176 +++++++++++++++++
 tb/tb_db_top_info_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_defines.sv
// Shared constants and types for the deblocking-filter top-neighbour info path.
//   DB_INFO_W : width of one top-neighbour info word (matches the RAM word)
//   DB_IDX_W  : 4x4-column index width, 16 columns per 64-pixel LCU
//   DB_LCUX_W : LCU-column index width; DB_LCUX_W + DB_IDX_W is the RAM address width
package db_defines;

   localparam int unsigned DB_INFO_W = 20;
   localparam int unsigned DB_IDX_W  = 4;
   localparam int unsigned DB_LCUX_W = 3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRead  = 2'd1,
      StDrain = 2'd2,
      StWrite = 2'd3
   } db_state_e;

endpackage

// File: rtl/db_top_info_ctrl.sv
// Port-A sequencer of the top-neighbour info RAM.
// On an LCU start it reads the 16 stored top-neighbour words of that LCU column and
// streams them to the filter, then collects the 16 bottom-row words the filter
// produces and writes them back to the same addresses for the next LCU row.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   start_i, lcu_x_i,
//   first_row_i              : LCU start pulse with its column and top-row flag
//   top_valid_o, top_idx_o,
//   top_info_o               : delivered top-neighbour word stream
//   upd_valid_i, upd_idx_i,
//   upd_info_i               : bottom-row words from the filter
//   done_o                   : pulse once all 16 columns have been written
//   err_o                    : sticky, an update arrived outside the write phase
//   cena_o, oena_o, wena_o,
//   addra_o, dataa_o, dataa_i: RAM port A (enables active-low, read data one cycle late)
module db_top_info_ctrl
   import db_defines::*;
#(
   parameter int unsigned INFO_W = DB_INFO_W,
   parameter int unsigned IDX_W  = DB_IDX_W,
   parameter int unsigned LCUX_W = DB_LCUX_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic [LCUX_W-1:0]         lcu_x_i,
   input  logic                      first_row_i,
   output logic                      top_valid_o,
   output logic [IDX_W-1:0]          top_idx_o,
   output logic [INFO_W-1:0]         top_info_o,
   input  logic                      upd_valid_i,
   input  logic [IDX_W-1:0]          upd_idx_i,
   input  logic [INFO_W-1:0]         upd_info_i,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      cena_o,
   output logic                      oena_o,
   output logic                      wena_o,
   output logic [LCUX_W+IDX_W-1:0]   addra_o,
   output logic [INFO_W-1:0]         dataa_o,
   input  logic [INFO_W-1:0]         dataa_i
);

   localparam int unsigned AddrW  = LCUX_W + IDX_W;
   localparam int unsigned NumCol = 1 << IDX_W;

   db_state_e           state_q, state_d;
   logic [LCUX_W-1:0]   base_q, base_d;
   logic                first_row_q, first_row_d;
   logic [IDX_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [NumCol-1:0]   wr_mask_q, wr_mask_d;
   logic                err_q, err_d;
   logic                done_q, done_d;
   logic                cena_q, cena_d;
   logic                oena_q, oena_d;
   logic                wena_q, wena_d;
   logic [AddrW-1:0]    addra_q, addra_d;
   logic [INFO_W-1:0]   dataa_q, dataa_d;
   logic                top_valid_q, top_valid_d;
   logic [IDX_W-1:0]    top_idx_q, top_idx_d;

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      first_row_d = first_row_q;
      rd_cnt_d    = rd_cnt_q;
      wr_mask_d   = wr_mask_q;
      done_d      = 1'b0;
      // RAM port is released unless this cycle's decision drives it
      cena_d      = 1'b1;
      oena_d      = 1'b1;
      wena_d      = 1'b1;
      addra_d     = addra_q;
      dataa_d     = dataa_q;
      // Read data returns one cycle after the address, so the stream is a delayed
      // copy of the read phase and its counter.
      top_valid_d = (state_q == StRead);
      top_idx_d   = rd_cnt_q;
      // Updates outside the write phase are dropped and flagged
      err_d       = err_q | (upd_valid_i && (state_q != StWrite));

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d     = StRead;
               base_d      = lcu_x_i;
               first_row_d = first_row_i;
               rd_cnt_d    = '0;
               wr_mask_d   = '0;
               // Top LCU row has no stored neighbours: keep the RAM idle
               cena_d      = first_row_i;
               oena_d      = first_row_i;
               addra_d     = {lcu_x_i, {IDX_W{1'b0}}};
            end
         end
         StRead: begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (rd_cnt_q == {IDX_W{1'b1}}) begin
               state_d = StDrain;
            end else begin
               cena_d  = first_row_q;
               oena_d  = first_row_q;
               addra_d = {base_q, rd_cnt_d};
            end
         end
         StDrain: begin
            state_d = StWrite;
         end
         StWrite: begin
            if (upd_valid_i) begin
               cena_d               = 1'b0;
               wena_d               = 1'b0;
               addra_d              = {base_q, upd_idx_i};
               dataa_d              = upd_info_i;
               wr_mask_d[upd_idx_i] = 1'b1;
               if (&wr_mask_d) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         base_q      <= '0;
         first_row_q <= 1'b0;
         rd_cnt_q    <= '0;
         wr_mask_q   <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         cena_q      <= 1'b1;
         oena_q      <= 1'b1;
         wena_q      <= 1'b1;
         addra_q     <= '0;
         dataa_q     <= '0;
         top_valid_q <= 1'b0;
         top_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         first_row_q <= first_row_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_mask_q   <= wr_mask_d;
         err_q       <= err_d;
         done_q      <= done_d;
         cena_q      <= cena_d;
         oena_q      <= oena_d;
         wena_q      <= wena_d;
         addra_q     <= addra_d;
         dataa_q     <= dataa_d;
         top_valid_q <= top_valid_d;
         top_idx_q   <= top_idx_d;
      end
   end

   assign top_valid_o = top_valid_q;
   assign top_idx_o   = top_idx_q;
   // First-row words are forced to zero; nothing valid reads as zero too
   assign top_info_o  = (top_valid_q && !first_row_q) ? dataa_i : '0;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign cena_o      = cena_q;
   assign oena_o      = oena_q;
   assign wena_o      = wena_q;
   assign addra_o     = addra_q;
   assign dataa_o     = dataa_q;

endmodule

// File: tb/tb_db_top_info_ctrl.sv
module tb_db_top_info_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_i = 1'b0;
   logic [2:0]  lcu_x_i = '0;
   logic        first_row_i = 1'b0;
   logic        top_valid_o;
   logic [3:0]  top_idx_o;
   logic [19:0] top_info_o;
   logic        upd_valid_i = 1'b0;
   logic [3:0]  upd_idx_i = '0;
   logic [19:0] upd_info_i = '0;
   logic        done_o;
   logic        err_o;
   logic        cena_o;
   logic        oena_o;
   logic        wena_o;
   logic [6:0]  addra_o;
   logic [19:0] dataa_o;
   logic [19:0] dataa_i;

   int n_cmp = 0;
   int n_fail = 0;

   // RAM port-A model plus a bench-side preload port
   logic [19:0] mem [0:127];
   logic [19:0] ram_q = '0;
   logic        pre_we = 1'b0;
   logic [6:0]  pre_addr = '0;
   logic [19:0] pre_data = '0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (!cena_o && !wena_o) mem[addra_o] <= dataa_o;
      if (!cena_o && wena_o) ram_q <= mem[addra_o];
   end
   assign dataa_i = ram_q;

   db_top_info_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .lcu_x_i    (lcu_x_i),
      .first_row_i(first_row_i),
      .top_valid_o(top_valid_o),
      .top_idx_o  (top_idx_o),
      .top_info_o (top_info_o),
      .upd_valid_i(upd_valid_i),
      .upd_idx_i  (upd_idx_i),
      .upd_info_i (upd_info_i),
      .done_o     (done_o),
      .err_o      (err_o),
      .cena_o     (cena_o),
      .oena_o     (oena_o),
      .wena_o     (wena_o),
      .addra_o    (addra_o),
      .dataa_o    (dataa_o),
      .dataa_i    (dataa_i)
   );

   task automatic preload(input logic [6:0] base, input logic [19:0] val);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         pre_we = 1'b1;
         pre_addr = base + 7'(i);
         pre_data = val + 20'(i);
      end
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({cena_o, oena_o, wena_o, top_valid_o, done_o, err_o} !== 6'b111000) begin
         n_fail++;
         $display("FAIL reset_ctrl got %b want 111000",
                  {cena_o, oena_o, wena_o, top_valid_o, done_o, err_o});
      end
      n_cmp++;
      if ({addra_o, top_idx_o} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset_addr_idx got %h/%h want 0/0", addra_o, top_idx_o);
      end
      n_cmp++;
      if ({dataa_o, top_info_o} !== 40'd0) begin
         n_fail++;
         $display("FAIL reset_data got %h/%h want 0/0", dataa_o, top_info_o);
      end
      rst = 1'b0;
   endtask

   // LCU column 3 read-back of preloaded words 0x10000+i
   task automatic test_normal_read();
      logic [6:0] ea;
      preload(7'h30, 20'h10000);
      @(negedge clk);
      lcu_x_i = 3'd3;
      first_row_i = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         if (c <= 16) begin
            ea = 7'h30 + 7'(c - 1);
            n_cmp++;
            if ({cena_o, wena_o, addra_o} !== {1'b0, 1'b1, ea}) begin
               n_fail++;
               $display("FAIL read_addr c=%0d got cena=%b wena=%b addr=%h want 0/1/%h",
                        c, cena_o, wena_o, addra_o, ea);
            end
         end
         if (c == 1) begin
            n_cmp++;
            if (top_valid_o !== 1'b0) begin
               n_fail++;
               $display("FAIL read_early_valid got %b want 0", top_valid_o);
            end
         end else begin
            n_cmp++;
            if ({top_valid_o, top_idx_o, top_info_o} !==
                {1'b1, 4'(c - 2), 20'h10000 + 20'(c - 2)}) begin
               n_fail++;
               $display("FAIL read_word c=%0d got v=%b idx=%0d info=%h want 1/%0d/%h",
                        c, top_valid_o, top_idx_o, top_info_o, c - 2, 20'h10000 + 20'(c - 2));
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if ({top_valid_o, cena_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL read_end got v=%b cena=%b want 0/1", top_valid_o, cena_o);
      end
   endtask

   // Continues in WRITE for column 3: idx 15 down to 0
   task automatic test_out_of_order_writes();
      logic [3:0] ix;
      for (int i = 0; i < 16; i++) begin
         ix = 4'(15 - i);
         upd_valid_i = 1'b1;
         upd_idx_i = ix;
         upd_info_i = 20'hA0000 | 20'(ix);
         @(negedge clk);
         n_cmp++;
         if ({cena_o, wena_o, addra_o, dataa_o} !== {2'b00, 3'd3, ix, 20'hA0000 | 20'(ix)}) begin
            n_fail++;
            $display("FAIL ooo_port i=%0d got cena=%b wena=%b addr=%h data=%h", i, cena_o,
                     wena_o, addra_o, dataa_o);
         end
         n_cmp++;
         if (done_o !== (i == 15)) begin
            n_fail++;
            $display("FAIL ooo_done i=%0d got %b want %b", i, done_o, i == 15);
         end
      end
      upd_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({done_o, cena_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL ooo_after got done=%b cena=%b want 0/1", done_o, cena_o);
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (mem[{3'd3, 4'(i)}] !== (20'hA0000 | 20'(i))) begin
            n_fail++;
            $display("FAIL ooo_ram idx=%0d got %h want %h", i, mem[{3'd3, 4'(i)}],
                     20'hA0000 | 20'(i));
         end
      end
   endtask

   // Column 5, top row: RAM untouched, zeros delivered (dataa_i holds a stale word)
   task automatic test_first_row();
      @(negedge clk);
      lcu_x_i = 3'd5;
      first_row_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      first_row_i = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         if (c <= 16) begin
            n_cmp++;
            if (cena_o !== 1'b1) begin
               n_fail++;
               $display("FAIL first_cena c=%0d got %b want 1", c, cena_o);
            end
         end
         if (c >= 2) begin
            n_cmp++;
            if ({top_valid_o, top_idx_o, top_info_o} !== {1'b1, 4'(c - 2), 20'h0}) begin
               n_fail++;
               $display("FAIL first_word c=%0d got v=%b idx=%0d info=%h want 1/%0d/0",
                        c, top_valid_o, top_idx_o, top_info_o, c - 2);
            end
         end
         @(negedge clk);
      end
   endtask

   // Continues in WRITE for column 5 with idx 5 written twice
   task automatic test_duplicate();
      logic [3:0]  seq [17] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                4'd5, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
      logic [19:0] d;
      for (int j = 0; j < 17; j++) begin
         d = (j == 5) ? 20'h11111 : (j == 10) ? 20'h22222 : (20'h50000 | 20'(seq[j]));
         upd_valid_i = 1'b1;
         upd_idx_i = seq[j];
         upd_info_i = d;
         @(negedge clk);
         n_cmp++;
         if (done_o !== (j == 16)) begin
            n_fail++;
            $display("FAIL dup_done j=%0d got %b want %b", j, done_o, j == 16);
         end
      end
      upd_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (mem[7'h55] !== 20'h22222) begin
         n_fail++;
         $display("FAIL dup_ram5 got %h want 22222", mem[7'h55]);
      end
      n_cmp++;
      if (mem[7'h54] !== 20'h50004) begin
         n_fail++;
         $display("FAIL dup_ram4 got %h want 50004", mem[7'h54]);
      end
   endtask

   task automatic test_protocol_errors();
      preload(7'h10, 20'h0C000);
      n_cmp++;
      if (err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pre got %b want 0", err_o);
      end
      @(negedge clk);
      lcu_x_i = 3'd1;
      first_row_i = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (2) @(negedge clk);
      // cycle k+3: stray update during READ
      upd_valid_i = 1'b1;
      upd_idx_i = 4'd2;
      upd_info_i = 20'h33333;
      @(negedge clk);
      upd_valid_i = 1'b0;
      n_cmp++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_set got %b want 1", err_o);
      end
      n_cmp++;
      if ({top_valid_o, top_idx_o, top_info_o} !== {1'b1, 4'd2, 20'h0C002}) begin
         n_fail++;
         $display("FAIL err_word2 got v=%b idx=%0d info=%h want 1/2/0c002",
                  top_valid_o, top_idx_o, top_info_o);
      end
      repeat (14) @(negedge clk);
      n_cmp++;
      if (mem[7'h12] !== 20'h0C002) begin
         n_fail++;
         $display("FAIL err_dropped got %h want 0c002", mem[7'h12]);
      end
      for (int i = 0; i < 8; i++) begin
         upd_valid_i = 1'b1;
         upd_idx_i = 4'(i);
         upd_info_i = 20'hE0000 | 20'(i);
         @(negedge clk);
      end
      // start during WRITE must not launch a read of column 6
      upd_valid_i = 1'b0;
      lcu_x_i = 3'd6;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n_cmp++;
      if (cena_o !== 1'b1) begin
         n_fail++;
         $display("FAIL start_ignored_cena got %b want 1", cena_o);
      end
      @(negedge clk);
      n_cmp++;
      if ({top_valid_o, cena_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL start_ignored_valid got v=%b cena=%b want 0/1", top_valid_o, cena_o);
      end
      for (int i = 8; i < 16; i++) begin
         upd_valid_i = 1'b1;
         upd_idx_i = 4'(i);
         upd_info_i = 20'hE0000 | 20'(i);
         @(negedge clk);
         n_cmp++;
         if ({addra_o, done_o} !== {3'd1, 4'(i), i == 15}) begin
            n_fail++;
            $display("FAIL start_ignored_wr i=%0d got addr=%h done=%b want %h/%b", i,
                     addra_o, done_o, {3'd1, 4'(i)}, i == 15);
         end
      end
      upd_valid_i = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky got %b want 1", err_o);
      end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      lcu_x_i = 3'd2;
      first_row_i = 1'b1;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      first_row_i = 1'b0;
      repeat (17) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         upd_valid_i = 1'b1;
         upd_idx_i = 4'(i);
         upd_info_i = 20'h70000 | 20'(i);
         @(negedge clk);
      end
      upd_valid_i = 1'b0;
      n_cmp++;
      if (cena_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstw_pre_cena got %b want 0", cena_o);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({cena_o, wena_o, done_o, err_o, top_valid_o} !== 5'b11000) begin
         n_fail++;
         $display("FAIL rstw_async got %b want 11000",
                  {cena_o, wena_o, done_o, err_o, top_valid_o});
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (mem[{3'd2, 4'(i)}] !== (20'h70000 | 20'(i))) begin
            n_fail++;
            $display("FAIL rstw_kept idx=%0d got %h want %h", i, mem[{3'd2, 4'(i)}],
                     20'h70000 | 20'(i));
         end
      end
      // Fresh read of column 3 after reset
      @(negedge clk);
      lcu_x_i = 3'd3;
      first_row_i = 1'b0;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= 18; c++) begin
         if (c == 1 || c == 18) begin
            n_cmp++;
            if (top_valid_o !== 1'b0) begin
               n_fail++;
               $display("FAIL rstw_edge_valid c=%0d got %b want 0", c, top_valid_o);
            end
         end else begin
            n_cmp++;
            if ({top_valid_o, top_idx_o, top_info_o} !==
                {1'b1, 4'(c - 2), 20'hA0000 | 20'(c - 2)}) begin
               n_fail++;
               $display("FAIL rstw_word c=%0d got v=%b idx=%0d info=%h want 1/%0d/%h",
                        c, top_valid_o, top_idx_o, top_info_o, c - 2,
                        20'hA0000 | 20'(c - 2));
            end
         end
         if (c < 18) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_normal_read();
      test_out_of_order_writes();
      test_first_row();
      test_duplicate();
      test_protocol_errors();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
